// File: rtl/mips_pkg.sv
// Shared defaults and FSM encoding for the instruction fetch slice.
package mips_pkg;
    localparam int         AW_DEF       = 8;
    localparam int         DW_DEF       = 16;
    localparam logic [7:0] RESET_PC_DEF = 8'h00;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_e;
endpackage

// File: rtl/fetch_buf.sv
// Two-entry in-order instruction buffer; entry 0 is the head presented downstream.
module fetch_buf
    import mips_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic [AW-1:0] push_pc,
    input  logic          pop,
    output logic [1:0]    occ,
    output logic [DW-1:0] head_data,
    output logic [AW-1:0] head_pc
);
    logic [1:0]    occ_q, occ_d, base;
    logic [DW-1:0] d0_q, d0_d, d1_q, d1_d;
    logic [AW-1:0] p0_q, p0_d, p1_q, p1_d;

    always_comb begin
        occ_d = occ_q;
        d0_d  = d0_q;
        d1_d  = d1_q;
        p0_d  = p0_q;
        p1_d  = p1_q;
        base  = occ_q;
        if (flush) begin
            occ_d = 2'd0;
        end else begin
            // Slot the incoming word lands in, after the head (if popped) has left.
            base = occ_q - {1'b0, pop};
            if (pop && occ_q == 2'd2) begin
                d0_d = d1_q;
                p0_d = p1_q;
            end
            if (push) begin
                if (base == 2'd0) begin
                    d0_d = push_data;
                    p0_d = push_pc;
                end else begin
                    d1_d = push_data;
                    p1_d = push_pc;
                end
            end
            occ_d = base + {1'b0, push};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= 2'd0;
            d0_q  <= '0;
            d1_q  <= '0;
            p0_q  <= '0;
            p1_q  <= '0;
        end else begin
            occ_q <= occ_d;
            d0_q  <= d0_d;
            d1_q  <= d1_d;
            p0_q  <= p0_d;
            p1_q  <= p1_d;
        end
    end

    assign occ       = occ_q;
    assign head_data = d0_q;
    assign head_pc   = p0_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues ROM reads with a one-cycle response, buffers up to two
// words for decode, and supports redirects; at most two words are ever owed.
module fetch_unit
    import mips_pkg::*;
#(
    parameter int            AW       = AW_DEF,
    parameter int            DW       = DW_DEF,
    parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEF)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_en,
    input  logic          i_redirect,
    input  logic [AW-1:0] i_redirect_pc,
    input  logic          i_ready,
    output logic          o_rom_rd,
    output logic [AW-1:0] o_rom_addr,
    input  logic [DW-1:0] i_rom_rdata,
    output logic          o_valid,
    output logic [DW-1:0] o_instr,
    output logic [AW-1:0] o_pc
);
    localparam logic [AW-1:0] PC_ONE = AW'(1);

    fetch_state_e  state_q, state_d;
    logic [AW-1:0] pc_q, pc_d, infl_addr_q, infl_addr_d;
    logic          infl_q, infl_d;
    logic [1:0]    occ;
    logic          pop, buf_push, buf_pop, buf_flush;
    logic [2:0]    level;

    assign o_valid = (occ != 2'd0);
    assign pop     = o_valid & i_ready;
    // Words owed after this edge's pop, counting the response landing now.
    assign level   = {1'b0, occ} + {2'b00, infl_q} - {2'b00, pop};

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        infl_d      = 1'b0;
        infl_addr_d = infl_addr_q;
        o_rom_rd    = 1'b0;
        o_rom_addr  = pc_q;
        buf_push    = 1'b0;
        buf_pop     = 1'b0;
        buf_flush   = 1'b0;
        if (!rst) begin
            if (i_redirect) begin
                buf_flush = 1'b1;
                if (i_en) begin
                    o_rom_rd    = 1'b1;
                    o_rom_addr  = i_redirect_pc;
                    pc_d        = i_redirect_pc + PC_ONE;
                    infl_d      = 1'b1;
                    infl_addr_d = i_redirect_pc;
                end else begin
                    pc_d = i_redirect_pc;
                end
            end else begin
                buf_push = infl_q;
                buf_pop  = pop;
                if (i_en && level <= 3'd1) begin
                    o_rom_rd    = 1'b1;
                    pc_d        = pc_q + PC_ONE;
                    infl_d      = 1'b1;
                    infl_addr_d = pc_q;
                end
            end
            case (state_q)
                ST_IDLE: if (i_en) state_d = ST_RUN;
                ST_RUN:  if (!i_en && !infl_q) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            infl_q      <= 1'b0;
            infl_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            infl_q      <= infl_d;
            infl_addr_q <= infl_addr_d;
        end
    end

    fetch_buf #(.AW(AW), .DW(DW)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (buf_flush),
        .push      (buf_push),
        .push_data (i_rom_rdata),
        .push_pc   (infl_addr_q),
        .pop       (buf_pop),
        .occ       (occ),
        .head_data (o_instr),
        .head_pc   (o_pc)
    );
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter AW, default 8, instruction ROM address width.
REQ-002 Parameter DW, default 16, instruction word width.
REQ-003 Parameter RESET_PC, default 8'h00, first fetch address after reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 i_en  input  1  fetch enable; low stops new ROM requests.
REQ-007 i_redirect  input  1  branch/jump redirect strobe.
REQ-008 i_redirect_pc  input  AW  redirect target address.
REQ-009 i_ready  input  1  downstream (decode) accepts o_instr this cycle.
REQ-010 o_rom_rd  output  1  ROM read strobe; drives the ROM read-enable.
REQ-011 o_rom_addr  output  AW  ROM read address.
REQ-012 i_rom_rdata  input  DW  ROM data, valid exactly 1 cycle after the request.
REQ-013 o_valid  output  1  o_instr/o_pc hold a valid instruction.
REQ-014 o_instr  output  DW  fetched instruction word.
REQ-015 o_pc  output  AW  address of o_instr.

Function
REQ-016 FSM states IDLE, RUN; IDLE->RUN when i_en=1; RUN->IDLE when i_en=0 and no request in flight.
REQ-017 Internal: pc (next request address), inflight flag + inflight address, 2-entry in-order buffer (occ 0..2).
REQ-018 Response capture keyed only on inflight flag, never on data value; word 0 is a legal instruction.
REQ-019 pop = o_valid & i_ready; head leaves buffer at that edge.
REQ-020 Issue when state RUN/entering RUN, i_en=1, and (occ + inflight - pop) <= 1; then o_rom_rd=1, o_rom_addr=pc, pc <= pc+1.
REQ-021 o_rom_rd, o_rom_addr combinational from registered state and inputs; o_rom_addr = pc when o_rom_rd=0.
REQ-022 Latency: request in cycle t -> data captured end of t+1 -> o_valid in t+2 (empty buffer).
REQ-023 Steady state with i_ready=1: one instruction per cycle, consecutive pc.
REQ-024 o_valid=0 -> o_instr, o_pc hold last value (not required zero outside reset).
REQ-025 Buffer never exceeds 2; no instruction lost, duplicated or reordered under any i_ready pattern.
REQ-026 pc arithmetic modulo 2^AW; 8'hFF+1 = 8'h00, no flag.
REQ-027 i_redirect=1: buffer flushed, response arriving this cycle discarded, request issued at i_redirect_pc if i_en=1 (else pc <= i_redirect_pc), pc <= i_redirect_pc+1.
REQ-028 i_redirect overrides pop and issue logic same cycle; o_valid=0 next cycle.
REQ-029 i_en falling: in-flight response still captured; no further requests.

Reset
REQ-030 rst=1 at edge: state IDLE, pc=RESET_PC, inflight=0, occ=0, o_valid=0, o_instr=0, o_pc=0; o_rom_rd=0 while rst=1.
REQ-031 ROM response arriving first cycle after reset is ignored (inflight cleared).
REQ-032 rst has priority over i_redirect, i_en, i_ready.

Structure
REQ-033 AW, DW, RESET_PC defaults and FSM state encodings in shared package mips_pkg.
REQ-034 2-entry buffer as sub-module fetch_buf (push/pop, data+pc, occ, flush).

Verification (ROM[k]=k unless stated)
REQ-035 Reset, i_en=1, i_ready=1 -> first o_rom_rd cycle t with addr 0; o_valid at t+2 with instr 0/pc 0, then 1,2,3 every cycle.
REQ-036 Streaming, i_ready=0 three cycles -> o_rom_rd drops when occ+inflight=2; on release instrs continue in order, no gap/dup.
REQ-037 Redirect to 8'h05 while addr 2 in flight -> instr 2 never valid; 2 cycles later o_valid with pc 5/instr 5, then 6.
REQ-038 Redirect to 8'hFE, stream -> pcs FE, FF, 00, 01.
REQ-039 rst pulse with occ=2 and one in flight -> next cycle all outputs 0; stale response dropped; restart from RESET_PC.
REQ-040 i_en drop mid-stream -> in-flight word delivered, no new o_rom_rd, FSM returns IDLE.
